normal_stage_arbiter: RTL and testbench

NORMAL_STAGE_ARBITER -- requirements
Module: normal_stage_arbiter

---
 rtl/rt_pkg.sv | 18 +
 rtl/tag_result_fifo.sv | 60 ++++++
 rtl/normal_stage_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_normal_stage_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared definitions for the normal-stage arbiter and its result buffer.
//   VEC3_W        width of a packed 3x32 vector (normal, hit position)
//   src_e         requester identity carried with every result
//   fifo_entry_w  width of one result-buffer entry {normal, tag, src}
package rt_pkg;

  localparam int VEC3_W = 96;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  function automatic int fifo_entry_w(input int tag_w);
    return VEC3_W + tag_w + 1;
  endfunction

endpackage

// File: rtl/tag_result_fifo.sv
// Result buffer between the shared normal pipeline and the shading stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_data       write one entry
//   pop                   consume the head entry (ignored when empty)
//   head                  head entry, zero while empty
//   not_empty             head is valid
//   count                 number of stored entries, 0..DEPTH
module tag_result_fifo
  import rt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = fifo_entry_w(16)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       not_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  // At full a push is only taken together with a pop; the slot being
  // written is the one the pop is releasing in the same cycle.
  assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/normal_stage_arbiter.sv
// Arbitrates plane-hit (A) and sphere-hit (B) requests onto one shared
// fixed-latency normal pipeline, tracks each request's {src, tag} alongside
// the pipeline, and buffers results for the shading stage.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   a_valid/a_ready, a_normal,
//   a_hit_pos, a_tag                   requester A (plane hits)
//   b_valid/b_ready, b_normal,
//   b_hit_pos, b_tag                   requester B (sphere hits)
//   pipe_normal, pipe_hit_pos,
//   pipe_new_data                      issue to the shared pipeline
//   pipe_result, pipe_valid            pipeline return
//   out_valid/out_ready, out_normal,
//   out_tag, out_src                   result stream to shading
//   err_orphan                         sticky: pipeline returned a result
//                                      nobody was waiting for
module normal_stage_arbiter
  import rt_pkg::*;
#(
  parameter int PIPE_LAT   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              a_valid,
  output logic              a_ready,
  input  logic [VEC3_W-1:0] a_normal,
  input  logic [VEC3_W-1:0] a_hit_pos,
  input  logic [TAG_W-1:0]  a_tag,

  input  logic              b_valid,
  output logic              b_ready,
  input  logic [VEC3_W-1:0] b_normal,
  input  logic [VEC3_W-1:0] b_hit_pos,
  input  logic [TAG_W-1:0]  b_tag,

  output logic [VEC3_W-1:0] pipe_normal,
  output logic [VEC3_W-1:0] pipe_hit_pos,
  output logic              pipe_new_data,
  input  logic [VEC3_W-1:0] pipe_result,
  input  logic              pipe_valid,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC3_W-1:0] out_normal,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_src,

  output logic              err_orphan
);

  localparam int ENTRY_W = fifo_entry_w(TAG_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W   = $clog2(PIPE_LAT + 2);
  localparam int SUM_W   = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  // Reset: assert asynchronously, release synchronously.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Arbitration and credit
  src_e             last_grant;
  logic [CNT_W-1:0] fifo_count;
  logic [INF_W-1:0] inflight;
  logic             credit_ok;
  logic             grant_a;
  logic             grant_b;
  logic             a_fire;
  logic             b_fire;
  logic             accept;

  // inflight counts every accepted request whose result has not yet reached
  // the buffer, including the one sitting in the issue register.
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);

  assign grant_a = a_valid && (!b_valid || (last_grant == SRC_B));
  assign grant_b = b_valid && (!a_valid || (last_grant == SRC_A));

  assign a_ready = rst_int_n && credit_ok && grant_a;
  assign b_ready = rst_int_n && credit_ok && grant_b;

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;
  assign accept = a_fire || b_fire;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pipe_new_data <= 1'b0;
      pipe_normal   <= '0;
      pipe_hit_pos  <= '0;
      last_grant    <= SRC_B;
    end else begin
      pipe_new_data <= accept;
      if (a_fire) begin
        pipe_normal  <= a_normal;
        pipe_hit_pos <= a_hit_pos;
        last_grant   <= SRC_A;
      end else if (b_fire) begin
        pipe_normal  <= b_normal;
        pipe_hit_pos <= b_hit_pos;
        last_grant   <= SRC_B;
      end
    end
  end

  // Tag pipe: stage 0 loads alongside the issue register, so the last stage
  // (index PIPE_LAT) lines up with the matching pipe_valid.
  logic             tp_valid [PIPE_LAT+1];
  src_e             tp_src   [PIPE_LAT+1];
  logic [TAG_W-1:0] tp_tag   [PIPE_LAT+1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i <= PIPE_LAT; i++) begin
        tp_valid[i] <= 1'b0;
        tp_src[i]   <= SRC_A;
        tp_tag[i]   <= '0;
      end
    end else begin
      tp_valid[0] <= accept;
      tp_src[0]   <= b_fire ? SRC_B : SRC_A;
      tp_tag[0]   <= b_fire ? b_tag : a_tag;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        tp_valid[i] <= tp_valid[i-1];
        tp_src[i]   <= tp_src[i-1];
        tp_tag[i]   <= tp_tag[i-1];
      end
    end
  end

  // An entry leaves the tag pipe every cycle its last stage is valid,
  // whether or not the pipeline answered.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) inflight <= '0;
    else            inflight <= inflight + INF_W'(accept) - INF_W'(tp_valid[PIPE_LAT]);
  end

  logic res_push;
  logic orphan;

  assign res_push = pipe_valid && tp_valid[PIPE_LAT];
  assign orphan   = pipe_valid && !tp_valid[PIPE_LAT];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)  err_orphan <= 1'b0;
    else if (orphan) err_orphan <= 1'b1;
  end

  // Result buffer
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign push_entry = {pipe_result, tp_tag[PIPE_LAT], tp_src[PIPE_LAT]};

  tag_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .push      (res_push),
    .push_data (push_entry),
    .pop       (out_ready),
    .head      (head_entry),
    .not_empty (out_valid),
    .count     (fifo_count)
  );

  assign out_normal = head_entry[ENTRY_W-1 -: VEC3_W];
  assign out_tag    = head_entry[TAG_W:1];
  assign out_src    = head_entry[0];

endmodule

// File: tb/tb_normal_stage_arbiter.sv
module tb_normal_stage_arbiter;
  import rt_pkg::*;

  localparam int PIPE_LAT   = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [95:0]       a_normal, a_hit_pos, b_normal, b_hit_pos;
  logic [TAG_W-1:0]  a_tag, b_tag;
  logic [95:0]       pipe_normal, pipe_hit_pos, pipe_result;
  logic              pipe_new_data, pipe_valid;
  logic              out_valid, out_ready, out_src, err_orphan;
  logic [95:0]       out_normal;
  logic [TAG_W-1:0]  out_tag;

  always #5 clk = ~clk;

  normal_stage_arbiter #(
    .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_normal(a_normal),
    .a_hit_pos(a_hit_pos), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_normal(b_normal),
    .b_hit_pos(b_hit_pos), .b_tag(b_tag),
    .pipe_normal(pipe_normal), .pipe_hit_pos(pipe_hit_pos),
    .pipe_new_data(pipe_new_data), .pipe_result(pipe_result),
    .pipe_valid(pipe_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_normal(out_normal),
    .out_tag(out_tag), .out_src(out_src), .err_orphan(err_orphan)
  );

  // Shared pipeline model: fixed latency, never reset, result = normal.
  logic        pl_v [PIPE_LAT];
  logic [95:0] pl_d [PIPE_LAT];
  logic        orph_inj;

  always @(posedge clk) begin
    pl_v[0] <= pipe_new_data;
    pl_d[0] <= pipe_normal;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pl_v[i] <= pl_v[i-1];
      pl_d[i] <= pl_d[i-1];
    end
  end

  assign pipe_valid  = pl_v[PIPE_LAT-1] | orph_inj;
  assign pipe_result = pl_d[PIPE_LAT-1];

  // Scoreboard
  typedef struct packed {
    logic [95:0]      n;
    logic [95:0]      h;
    logic [TAG_W-1:0] t;
    logic             s;
  } item_t;

  item_t exp_q[$];
  item_t iss_q[$];
  logic  src_log[$];
  int    vectors    = 0;
  int    miscompares = 0;
  int    outstanding = 0;
  src_e  last_win    = SRC_B;
  bit    chk_en      = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Reference model: round-robin with "A wins first tie", and at most
  // FIFO_DEPTH requests accepted but not yet delivered to shading.
  always @(negedge clk) begin
    logic  ga, gb, ok, fa, fb, pop;
    item_t it;
    if (!rst_n) begin
      outstanding = 0;
      last_win    = SRC_B;
      exp_q.delete();
      iss_q.delete();
    end else if (chk_en) begin
      ok = (outstanding < FIFO_DEPTH);
      ga = a_valid && (!b_valid || last_win == SRC_B);
      gb = b_valid && !ga;
      check("a_ready", 128'(a_ready), 128'(ga && ok));
      check("b_ready", 128'(b_ready), 128'(gb && ok));
      fa = ga && ok;
      fb = gb && ok;
      if (fa) begin
        it = '{n: a_normal, h: a_hit_pos, t: a_tag, s: 1'b0};
        exp_q.push_back(it);
        iss_q.push_back(it);
        last_win = SRC_A;
      end
      if (fb) begin
        it = '{n: b_normal, h: b_hit_pos, t: b_tag, s: 1'b1};
        exp_q.push_back(it);
        iss_q.push_back(it);
        last_win = SRC_B;
      end
      pop = out_valid && out_ready;
      outstanding = outstanding + int'(fa || fb) - int'(pop);
    end
  end

  // Issue monitor
  always @(negedge clk) begin
    item_t it;
    if (rst_n && pipe_new_data) begin
      if (iss_q.size() == 0) begin
        check("issue_unexpected", 128'(pipe_new_data), 128'(0));
      end else begin
        it = iss_q.pop_front();
        check("pipe_normal", 128'(pipe_normal), 128'(it.n));
        check("pipe_hit_pos", 128'(pipe_hit_pos), 128'(it.h));
      end
    end
  end

  // Output monitor: head must match the oldest expected result whenever
  // presented (also covers stability under backpressure); pop on handshake.
  always @(negedge clk) begin
    item_t it;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 128'(out_valid), 128'(0));
      end else begin
        it = exp_q[0];
        check("out_normal", 128'(out_normal), 128'(it.n));
        check("out_tag", 128'(out_tag), 128'(it.t));
        check("out_src", 128'(out_src), 128'(it.s));
        if (out_ready) begin
          src_log.push_back(out_src);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drain();
    int n = 0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check("drain_results", 128'(exp_q.size()), 128'(0));
    check("drain_issues", 128'(iss_q.size()), 128'(0));
  endtask

  // Random traffic; a request is held until accepted.
  task automatic run_random(input int cycles, input int pv, input int pr);
    logic fa, fb;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (fa || !a_valid) begin
        a_valid   = ($urandom_range(99) < pv);
        a_normal  = rnd96();
        a_hit_pos = rnd96();
        a_tag     = TAG_W'($urandom());
      end
      if (fb || !b_valid) begin
        b_valid   = ($urandom_range(99) < pv);
        b_normal  = rnd96();
        b_hit_pos = rnd96();
        b_tag     = TAG_W'($urandom());
      end
      out_ready = ($urandom_range(99) < pr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   na, nb, lat;
    logic fa, fb;
    orph_inj  = 1'b0;
    rst_n     = 1'b0;
    a_valid   = 1'b0;  b_valid   = 1'b0;
    a_normal  = '0;    b_normal  = '0;
    a_hit_pos = '0;    b_hit_pos = '0;
    a_tag     = '0;    b_tag     = '0;
    out_ready = 1'b0;

    repeat (3) tick();
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    check("rst_a_ready", 128'(a_ready), 128'(0));
    check("rst_b_ready", 128'(b_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_new_data", 128'(pipe_new_data), 128'(0));
    check("rst_err_orphan", 128'(err_orphan), 128'(0));
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;

    // Tie: both held valid, A wins first, then alternate.
    src_log.delete();
    out_ready = 1'b1;
    na = 0; nb = 0;
    a_valid = 1'b1; a_tag = 16'h0001; a_normal = rnd96(); a_hit_pos = rnd96();
    b_valid = 1'b1; b_tag = 16'h1001; b_normal = rnd96(); b_hit_pos = rnd96();
    for (int c = 0; c < 100 && (na < 4 || nb < 4); c++) begin
      @(negedge clk);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (fa) begin
        na++;
        a_tag = TAG_W'(16'h0001 + na); a_normal = rnd96(); a_hit_pos = rnd96();
        if (na >= 4) a_valid = 1'b0;
      end
      if (fb) begin
        nb++;
        b_tag = TAG_W'(16'h1001 + nb); b_normal = rnd96(); b_hit_pos = rnd96();
        if (nb >= 4) b_valid = 1'b0;
      end
    end
    drain();
    check("tie_count", 128'(src_log.size() >= 4), 128'(1));
    if (src_log.size() >= 4)
      for (int i = 0; i < 4; i++) check("tie_src", 128'(src_log[i]), 128'(i % 2));

    // Latency: one A request with out_ready high.
    out_ready = 1'b1;
    a_valid = 1'b1; a_tag = 16'h00AA; a_normal = rnd96(); a_hit_pos = rnd96();
    tick();
    a_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 128'(lat), 128'(PIPE_LAT + 2));
    check("latency_tag", 128'(out_tag), 128'(16'h00AA));
    drain();

    // Backpressure: six A requests, shading stalled.
    out_ready = 1'b0;
    na = 0;
    a_valid = 1'b1; a_tag = 16'h2001; a_normal = rnd96(); a_hit_pos = rnd96();
    repeat (10) begin
      @(negedge clk);
      fa = a_valid && a_ready;
      @(posedge clk);
      #1;
      if (fa) begin
        na++;
        a_tag = TAG_W'(16'h2001 + na); a_normal = rnd96(); a_hit_pos = rnd96();
      end
    end
    check("bp_accepted", 128'(na), 128'(FIFO_DEPTH));
    check("bp_a_ready_low", 128'(a_ready), 128'(0));
    out_ready = 1'b1;
    for (int c = 0; c < 50 && na < 6; c++) begin
      @(negedge clk);
      fa = a_valid && a_ready;
      @(posedge clk);
      #1;
      if (fa) begin
        na++;
        a_tag = TAG_W'(16'h2001 + na); a_normal = rnd96(); a_hit_pos = rnd96();
        if (na >= 6) a_valid = 1'b0;
      end
    end
    check("bp_total", 128'(na), 128'(6));
    drain();

    // Full boundary: fill the buffer, then drain while traffic keeps coming.
    out_ready = 1'b0;
    run_random(12, 100, 0);
    out_ready = 1'b1;
    run_random(40, 100, 100);
    drain();

    // Random traffic.
    run_random(400, 60, 70);
    drain();

    // Reset in the middle of traffic.
    run_random(30, 80, 50);
    rst_n  = 1'b0;
    chk_en = 1'b0;
    #1;
    check("mid_rst_a_ready", 128'(a_ready), 128'(0));
    check("mid_rst_b_ready", 128'(b_ready), 128'(0));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_out_normal", 128'(out_normal), 128'(0));
    check("mid_rst_out_tag", 128'(out_tag), 128'(0));
    check("mid_rst_new_data", 128'(pipe_new_data), 128'(0));
    check("mid_rst_pipe_normal", 128'(pipe_normal), 128'(0));
    check("mid_rst_pipe_hit_pos", 128'(pipe_hit_pos), 128'(0));
    check("mid_rst_err_orphan", 128'(err_orphan), 128'(0));
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_err_orphan", 128'(err_orphan), 128'(0));
    chk_en = 1'b1;
    run_random(80, 70, 80);
    drain();

    // Orphan result.
    check("pre_orphan_err", 128'(err_orphan), 128'(0));
    orph_inj = 1'b1;
    tick();
    orph_inj = 1'b0;
    check("orphan_err", 128'(err_orphan), 128'(1));
    check("orphan_out_valid", 128'(out_valid), 128'(0));
    repeat (3) tick();
    check("orphan_sticky", 128'(err_orphan), 128'(1));
    check("orphan_out_valid_late", 128'(out_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
